// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer, 1-cycle push-to-head latency.
// Backpressure: if_ready drops only at count==DEPTH; id_ready=0 holds the head stable.
module inst_queue #(
   parameter int INST_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int DEPTH     = 4,
   parameter int AFULL_LVL = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       if_valid,
   output logic                       if_ready,
   input  logic [INST_W-1:0]          if_inst_in,
   input  logic [ADDR_W-1:0]          if_addr_in,
   output logic                       id_valid,
   input  logic                       id_ready,
   output logic [INST_W-1:0]          id_inst_out,
   output logic [ADDR_W-1:0]          id_addr_out,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       almost_full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADDR_W-1:0] addr;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;
   logic          not_full;
   logic          not_empty;
   entry_t        head;

   assign not_full  = (cnt != FULL_CNT);
   assign not_empty = (cnt != '0);

   // Ready/valid come from registered count only, so no id_ready->if_ready path exists.
   assign if_ready = !rst && not_full;
   assign id_valid = not_empty;

   assign push = if_valid && if_ready && !flush;
   assign pop  = id_valid && id_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + PW'(1);
         if (pop)  rp <= rp + PW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= {if_inst_in, if_addr_in};
   end

   always_comb begin
      head = '0;
      if (not_empty) head = mem[rp];
   end

   assign id_inst_out = head.inst;
   assign id_addr_out = head.addr;
   assign count       = cnt;
   assign almost_full = (cnt >= AFULL_CNT);

endmodule

// File: tb/tb_inst_queue.sv
// Directed vectors, streaming/wrap sequence and randomized scoreboard run for inst_queue.
module tb_inst_queue;

   logic        clk = 1'b0;
   logic        rst, flush, if_valid, id_ready;
   logic        if_ready, id_valid, almost_full;
   logic [31:0] if_inst_in, if_addr_in, id_inst_out, id_addr_out;
   logic [2:0]  count;

   always #5 clk = ~clk;

   inst_queue #(.INST_W(32), .ADDR_W(32), .DEPTH(4), .AFULL_LVL(3)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_inst_in(if_inst_in), .if_addr_in(if_addr_in),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_inst_out(id_inst_out), .id_addr_out(id_addr_out),
      .count(count), .almost_full(almost_full)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        r, f, iv, ir;
      logic [31:0] inst, addr;
      int          cnt;
      logic        vld;
      logic [31:0] einst, eaddr;
      logic        rdy, af;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic iv, input logic ir,
                        input logic [31:0] i, input logic [31:0] a);
      rst = r; flush = f; if_valid = iv; id_ready = ir; if_inst_in = i; if_addr_in = a;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic ir,
                               input logic [31:0] i, input logic [31:0] a, input int c,
                               input logic v, input logic [31:0] ei, input logic [31:0] ea,
                               input logic rd, input logic af);
      vec_t t;
      t.r = r; t.f = f; t.iv = iv; t.ir = ir; t.inst = i; t.addr = a;
      t.cnt = c; t.vld = v; t.einst = ei; t.eaddr = ea; t.rdy = rd; t.af = af;
      return t;
   endfunction

   task automatic check_outputs(input string tag, input int c, input logic v,
                                input logic [31:0] ei, input logic [31:0] ea,
                                input logic rd, input logic af);
      chk({tag, ".count"},    64'(count),       64'(c));
      chk({tag, ".id_valid"}, 64'(id_valid),    64'(v));
      chk({tag, ".inst"},     64'(id_inst_out), 64'(ei));
      chk({tag, ".addr"},     64'(id_addr_out), 64'(ea));
      chk({tag, ".if_ready"}, 64'(if_ready),    64'(rd));
      chk({tag, ".afull"},    64'(almost_full), 64'(af));
   endtask

   logic [31:0] q_inst[$];
   logic [31:0] q_addr[$];

   initial begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0);

      // reset with fetch offering
      vecs.push_back(mk(1,0,1,0, 32'h00000013, 32'h0,  0,0, 32'h0, 32'h0, 0,0));
      vecs.push_back(mk(1,0,1,0, 32'h00000013, 32'h0,  0,0, 32'h0, 32'h0, 0,0));
      vecs.push_back(mk(0,0,0,0, 32'h0,        32'h0,  0,0, 32'h0, 32'h0, 1,0));
      // fill
      vecs.push_back(mk(0,0,1,0, 32'h00000013, 32'h0,  1,1, 32'h00000013, 32'h0, 1,0));
      vecs.push_back(mk(0,0,1,0, 32'h00100093, 32'h4,  2,1, 32'h00000013, 32'h0, 1,0));
      vecs.push_back(mk(0,0,1,0, 32'h00200113, 32'h8,  3,1, 32'h00000013, 32'h0, 1,1));
      vecs.push_back(mk(0,0,1,0, 32'h00300193, 32'hC,  4,1, 32'h00000013, 32'h0, 0,1));
      vecs.push_back(mk(0,0,1,0, 32'h00400213, 32'h10, 4,1, 32'h00000013, 32'h0, 0,1));
      // full with simultaneous pop: pop only
      vecs.push_back(mk(0,0,1,1, 32'h00400213, 32'h10, 3,1, 32'h00100093, 32'h4, 1,1));
      // drain
      vecs.push_back(mk(0,0,0,1, 32'h0, 32'h0, 2,1, 32'h00200113, 32'h8, 1,0));
      vecs.push_back(mk(0,0,0,1, 32'h0, 32'h0, 1,1, 32'h00300193, 32'hC, 1,0));
      vecs.push_back(mk(0,0,0,1, 32'h0, 32'h0, 0,0, 32'h0,        32'h0, 1,0));
      // flush at count 3 with push and pop offered
      vecs.push_back(mk(0,0,1,0, 32'hA0, 32'h20, 1,1, 32'hA0, 32'h20, 1,0));
      vecs.push_back(mk(0,0,1,0, 32'hA1, 32'h24, 2,1, 32'hA0, 32'h20, 1,0));
      vecs.push_back(mk(0,0,1,0, 32'hA2, 32'h28, 3,1, 32'hA0, 32'h20, 1,1));
      vecs.push_back(mk(0,1,1,1, 32'hA3, 32'h2C, 0,0, 32'h0,  32'h0,  1,0));
      vecs.push_back(mk(0,0,1,0, 32'h11111111, 32'h100, 1,1, 32'h11111111, 32'h100, 1,0));
      vecs.push_back(mk(0,0,0,1, 32'h0, 32'h0, 0,0, 32'h0, 32'h0, 1,0));
      // reset beats flush and handshakes
      vecs.push_back(mk(0,0,1,0, 32'hB0, 32'h200, 1,1, 32'hB0, 32'h200, 1,0));
      vecs.push_back(mk(1,1,1,0, 32'hB1, 32'h204, 0,0, 32'h0,  32'h0,   0,0));
      vecs.push_back(mk(0,0,0,0, 32'h0,  32'h0,   0,0, 32'h0,  32'h0,   1,0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r, vecs[i].f, vecs[i].iv, vecs[i].ir, vecs[i].inst, vecs[i].addr);
         tick();
         check_outputs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].vld,
                       vecs[i].einst, vecs[i].eaddr, vecs[i].rdy, vecs[i].af);
      end

      // streaming across pointer wrap: head after edge k is the entry pushed at edge k
      for (int k = 0; k < 20; k++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 32'hC0DE0000 + 32'(k), 32'h1000 + 32'(4 * k));
         tick();
         chk($sformatf("stream%0d.count", k), 64'(count), 64'd1);
         chk($sformatf("stream%0d.addr", k), 64'(id_addr_out), 64'(32'h1000 + 32'(4 * k)));
         chk($sformatf("stream%0d.inst", k), 64'(id_inst_out), 64'(32'hC0DE0000 + 32'(k)));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      tick();
      check_outputs("stream_end", 0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // randomized run against a scoreboard
      begin
         logic [31:0] next_addr = 32'h8000;
         logic        p_hold = 1'b0;
         logic [31:0] p_inst = '0, p_addr = '0;
         for (int c = 0; c < 10000; c++) begin
            logic f, iv, ir, m_push, m_pop;
            logic [31:0] ri;
            chk("rnd.count", 64'(count), 64'(q_inst.size()));
            chk("rnd.cnt_le_depth", 64'(count <= 3'd4), 64'd1);
            chk("rnd.id_valid", 64'(id_valid), 64'(q_inst.size() != 0));
            chk("rnd.if_ready", 64'(if_ready), 64'(q_inst.size() != 4));
            chk("rnd.afull", 64'(almost_full), 64'(q_inst.size() >= 3));
            if (q_inst.size() != 0) begin
               chk("rnd.inst", 64'(id_inst_out), 64'(q_inst[0]));
               chk("rnd.addr", 64'(id_addr_out), 64'(q_addr[0]));
            end else begin
               chk("rnd.bubble", 64'({id_inst_out, id_addr_out}), 64'd0);
            end
            if (p_hold) chk("rnd.hold", 64'({id_inst_out, id_addr_out}), 64'({p_inst, p_addr}));

            f  = ($urandom_range(99) < 5);
            iv = ($urandom_range(99) < 60);
            ir = ($urandom_range(99) < 50);
            ri = $urandom;
            drive(1'b0, f, iv, ir, ri, next_addr);
            m_push = iv && (q_inst.size() != 4) && !f;
            m_pop  = ir && (q_inst.size() != 0) && !f;
            p_hold = (q_inst.size() != 0) && !ir && !f;
            p_inst = id_inst_out;
            p_addr = id_addr_out;
            tick();
            if (f) begin
               q_inst.delete();
               q_addr.delete();
            end else begin
               if (m_pop) begin
                  void'(q_inst.pop_front());
                  void'(q_addr.pop_front());
               end
               if (m_push) begin
                  q_inst.push_back(ri);
                  q_addr.push_back(next_addr);
                  next_addr = next_addr + 32'd4;
               end
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised fetch-to-decode instruction queue. It is the multi-entry successor of the single IF/ID pipeline register and sits between the fetch stage and the decode stage. Fetch pushes (instruction, PC) pairs with a valid/ready handshake and decode pops them the same way, so the two stages decouple by up to DEPTH entries. A flush input drops all queued entries in one cycle on jump or branch redirect, and empty cycles present a zero bubble to decode.

## Interface
Parameters:
- INST_W, default 32: instruction width.
- ADDR_W, default 32: PC width.
- DEPTH, default 4: number of entries. Must be a power of two, ≥2.
- AFULL_LVL, default DEPTH-1: count at or above which almost_full asserts. Range 1..DEPTH.

Ports:
- clk, in, 1: sole clock; all state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- flush, in, 1: discard all entries; registered effect.
- if_valid, in, 1: fetch offers an entry.
- if_ready, out, 1: queue can accept an entry.
- if_inst_in, in, INST_W: instruction from fetch.
- if_addr_in, in, ADDR_W: PC of that instruction.
- id_valid, out, 1: head entry presented to decode.
- id_ready, in, 1: decode consumes the head this cycle.
- id_inst_out, out, INST_W: head instruction; 0 when id_valid=0.
- id_addr_out, out, ADDR_W: head PC; 0 when id_valid=0.
- count, out, $clog2(DEPTH)+1: number of occupied entries.
- almost_full, out, 1: count ≥ AFULL_LVL.

## Operation
- Storage: circular buffer of DEPTH {inst, addr} entries, with write pointer wp, read pointer rp (each $clog2(DEPTH) bits, wrapping DEPTH-1→0) and a count register.
- push = if_valid & if_ready & !flush.
- pop = id_valid & id_ready & !flush.
- On push, write {if_inst_in, if_addr_in} at wp, then wp+1.
- On pop, rp+1.
- count update:
  - push only: count+1.
  - pop only: count−1.
  - both, or neither: count unchanged.
- Push and pop in the same cycle are legal at any 0<count<DEPTH.
- At count==0, only a push is possible.
- At count==DEPTH, only a pop is possible.
- if_ready = !rst & (count != DEPTH).
  - No pass-through when full: a pop in the same cycle does not enable a push.
- id_valid = (count != 0).
- id_inst_out and id_addr_out are the entry at rp when id_valid, else 0 (bubble).
- almost_full = (count ≥ AFULL_LVL).
- flush: on the next edge wp=rp=count=0. Any push or pop offered in the flush cycle is ignored. Storage contents need not be cleared.
- rst: on the next edge wp=rp=count=0, with priority over flush and the handshakes.
- Reset values: if_ready=0 while rst is high and 1 after. id_valid=0, id_inst_out=0, id_addr_out=0, count=0, almost_full=0 (AFULL_LVL≥1).
- Order is preserved: entries leave in exact push order, with the PC paired to its instruction.

## Timing
- Push-to-output latency is 1 cycle. Data pushed at edge N appears on id_* with id_valid=1 after edge N; there is no same-cycle fetch→decode bypass.
- Throughput is one push and one pop per cycle sustained.
- if_ready, id_valid, id_* and almost_full are functions of registered state only. There is no combinational path from id_ready to if_ready, nor from if_valid to id_valid.
- A flush asserted in cycle N gives id_valid=0 and count=0 in cycle N+1.
  - A push in cycle N+1 is accepted normally and is visible in N+2.
- Decode holding id_ready=0 with count≥1 keeps the head stable. id_* must not change until it is popped.

## Test plan
- Reset: hold rst 2 cycles with if_valid=1. Required: count=0, id_valid=0, id_inst_out=0, id_addr_out=0, if_ready=0 during reset; if_ready=1 the cycle after release.
- Fill/drain (DEPTH=4): id_ready=0, push inst 0x00000013, 0x00100093, 0x00200113, 0x00300193 at PCs 0x0, 0x4, 0x8, 0xC. Required: count 1,2,3,4; almost_full from count=3; if_ready=0 at count=4. A fifth push is held off. With id_ready=1, the entries emerge in PC order 0x0..0xC, then id_valid=0 with zero outputs.
- Full with simultaneous pop: at count=4 assert if_valid and id_ready. Required: pop only, count→3, next cycle if_ready=1.
- Streaming and wrap: if_valid=id_ready=1 for 20 cycles with PC incrementing by 4. Required: count steady at 1 after first push; every PC appears exactly once in order across pointer wrap.
- Flush: count=3, assert flush together with if_valid=1 and id_ready=1. Required: next cycle count=0, id_valid=0, id_inst_out=0. Neither the offered push nor the pop takes effect. Push PC 0x100 in the next cycle; it appears as the head one cycle later.
- Random: random if_valid/id_ready/flush (flush 5%) for 10k cycles against a scoreboard queue. Required: no loss, duplication or reorder. count never exceeds DEPTH. id_* stable while id_valid & !id_ready.
